// File: rtl/kws_cmd_sequencer.sv
// kws_cmd_sequencer: host-loaded opcode program issued to the KWS layer FSM
// one command at a time, with per-command timeout and opcode legality check.
module kws_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [3:0]       prog_data,
  input  logic [IDX_W:0]   prog_len,
  input  logic             run,
  input  logic             abort,
  output logic             start,
  output logic [3:0]       opcode,
  input  logic             done,
  output logic             busy,
  output logic [IDX_W-1:0] cmd_idx,
  output logic             seq_done,
  output logic             timeout_err,
  output logic             op_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W+1)'(DEPTH);
  // Final WAIT count: expiry lands TIMEOUT cycles after the start pulse
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  logic [1:0]       r_state;
  logic [3:0]       r_slot [DEPTH];
  logic [IDX_W:0]   r_len;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic [3:0]       r_opcode;
  logic             r_busy;
  logic [IDX_W-1:0] r_cmd_idx;
  logic             r_seq_done;
  logic             r_tmo;
  logic             r_operr;

  logic [IDX_W:0]   w_len;
  logic             w_last;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [3:0]       w_nxt_op;
  logic [3:0]       w_op0;

  function automatic logic f_legal(input logic [3:0] op);
    return (op >= 4'd3) && (op <= 4'd9);
  endfunction

  assign w_len     = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_nxt_idx = r_idx + 1'b1;
  assign w_nxt_op  = r_slot[w_nxt_idx];
  assign w_op0     = r_slot[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_opcode   <= '0;
      r_busy     <= 1'b0;
      r_cmd_idx  <= '0;
      r_seq_done <= 1'b0;
      r_tmo      <= 1'b0;
      r_operr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_start    <= 1'b0;
      r_seq_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (prog_we) begin
            r_slot[prog_addr] <= prog_data;
          end
          if (run && !abort) begin
            r_tmo   <= 1'b0;
            r_operr <= 1'b0;
            r_len   <= w_len;
            r_idx   <= '0;
            if (w_len == '0) begin
              r_seq_done <= 1'b1;
            end else if (!f_legal(w_op0)) begin
              r_operr <= 1'b1;
            end else begin
              r_state   <= S_ISSUE;
              r_busy    <= 1'b1;
              r_start   <= 1'b1;
              r_opcode  <= w_op0;
              r_cmd_idx <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (done && w_last) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b1;
          end else if (done) begin
            r_idx <= w_nxt_idx;
            if (!f_legal(w_nxt_op)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_operr <= 1'b1;
            end else begin
              r_state   <= S_ISSUE;
              r_start   <= 1'b1;
              r_opcode  <= w_nxt_op;
              r_cmd_idx <= w_nxt_idx;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start       = r_start;
  assign opcode      = r_opcode;
  assign busy        = r_busy;
  assign cmd_idx     = r_cmd_idx;
  assign seq_done    = r_seq_done;
  assign timeout_err = r_tmo;
  assign op_err      = r_operr;

endmodule

// File: tb/tb_kws_cmd_sequencer.sv
// tb_kws_cmd_sequencer: randomized host/layer-FSM stimulus checked
// against a transaction-level model of the command sequencer.
module tb_kws_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [3:0] prog_data = '0;
  logic [3:0] prog_len = '0;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       done = 1'b0;
  logic       start;
  logic [3:0] opcode;
  logic       busy;
  logic [2:0] cmd_idx;
  logic       seq_done;
  logic       timeout_err;
  logic       op_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mem [DEPTH];

  always #5 clk = ~clk;

  kws_cmd_sequencer #(
    .DEPTH(DEPTH),
    .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_len(prog_len),
    .run(run),
    .abort(abort),
    .start(start),
    .opcode(opcode),
    .done(done),
    .busy(busy),
    .cmd_idx(cmd_idx),
    .seq_done(seq_done),
    .timeout_err(timeout_err),
    .op_err(op_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [3:0] op);
    return (op >= 4'd3) && (op <= 4'd9);
  endfunction

  task automatic load(input int a, input logic [3:0] d);
    prog_we   = 1'b1;
    prog_addr = 3'(a);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    mem[a]    = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_seqd"}, seq_done, 0);
  endtask

  // Run a program: done arrives d cycles after each start (d in [dlo,dhi],
  // d >= TMO means never). ab>0 aborts one command ab cycles after start.
  task automatic run_prog(input int plen, input int dlo, input int dhi,
                          input int ab, input bit noise);
    int L;
    int d;
    int ai;
    L = (plen > DEPTH) ? DEPTH : plen;
    ai = (L > 0) ? $urandom_range(L - 1, 0) : 0;
    prog_len = 4'(plen);
    run = 1'b1;
    tick();
    run = 1'b0;
    if (L == 0) begin
      chk("len0_seqd", seq_done, 1);
      chk("len0_start", start, 0);
      chk("len0_busy", busy, 0);
      tick();
      chk("len0_pulse", seq_done, 0);
      return;
    end
    if (!legal(mem[0])) begin
      chk("op0_err", op_err, 1);
      chk("op0_tmo", timeout_err, 0);
      chk_idle("op0");
      return;
    end
    chk("run_errs", {timeout_err, op_err}, 0);
    for (int i = 0; i < L; i++) begin
      chk("start", start, 1);
      chk("opcode", opcode, mem[i]);
      chk("cmd_idx", cmd_idx, i);
      chk("busy_issue", busy, 1);
      d = $urandom_range(dhi, dlo);
      if (ab > 0 && i == ai) d = TMO;
      for (int k = 0; k < TMO; k++) begin
        if (k == 0) begin
          done = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        end else if (ab > 0 && i == ai && k == ab) begin
          abort = 1'b1;
        end else if (k == d) begin
          done = 1'b1;
        end else if (noise && k == 1) begin
          prog_we = 1'b1;
          prog_addr = 3'd1;
          prog_data = 4'hf;
          run = 1'b1;
        end else if (noise) begin
          prog_we = 1'($urandom_range(1, 0));
          prog_addr = 3'($urandom_range(7, 0));
          prog_data = 4'($urandom_range(15, 0));
          run = 1'($urandom_range(1, 0));
        end
        tick();
        done = 1'b0;
        abort = 1'b0;
        prog_we = 1'b0;
        run = 1'b0;
        if (ab > 0 && i == ai && k == ab) begin
          chk_idle("abort");
          tick();
          done = 1'b1;
          tick();
          done = 1'b0;
          chk_idle("late_done");
          tick();
          chk_idle("late_done2");
          return;
        end
        if (k == d) break;
        if (k + 1 == TMO) begin
          chk("tmo_err", timeout_err, 1);
          chk("tmo_operr", op_err, 0);
          chk_idle("tmo");
          tick();
          chk("tmo_seqd", seq_done, 0);
          return;
        end
        chk("wait_start", start, 0);
        chk("wait_busy", busy, 1);
      end
      if (i == L - 1) begin
        chk("fin_seqd", seq_done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_start", start, 0);
        chk("fin_errs", {timeout_err, op_err}, 0);
        tick();
        chk("fin_pulse", seq_done, 0);
        chk("op_hold", opcode, mem[i]);
        return;
      end
      if (!legal(mem[i + 1])) begin
        chk("opn_err", op_err, 1);
        chk_idle("opn");
        tick();
        chk("opn_start", start, 0);
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'd0;
    rst_n = 1'b0;
    run = 1'b1;
    prog_we = 1'b1;
    tick();
    tick();
    run = 1'b0;
    prog_we = 1'b0;
    chk("rst_outs", {start, opcode, busy, cmd_idx, seq_done,
                     timeout_err, op_err}, 0);
    rst_n = 1'b1;
    tick();
    // unloaded program faults
    run_prog(1, 1, 1, 0, 1'b0);

    load(0, 4'd3);
    load(1, 4'd4);
    run_prog(2, 5, 5, 0, 1'b0);

    load(0, 4'd7);
    run_prog(1, TMO, TMO, 0, 1'b0);
    run_prog(1, 2, 2, 0, 1'b0);

    load(0, 4'd8);
    load(1, 4'd15);
    run_prog(2, 3, 3, 0, 1'b0);

    load(1, 4'd9);
    run_prog(2, 8, 8, 3, 1'b0);
    run_prog(0, 1, 1, 0, 1'b0);

    // run together with abort in IDLE is dropped
    prog_len = 4'd1;
    run = 1'b1;
    abort = 1'b1;
    tick();
    run = 1'b0;
    abort = 1'b0;
    chk_idle("abort_run");

    for (int i = 0; i < DEPTH; i++) load(i, 4'($urandom_range(9, 3)));
    run_prog(12, 1, 3, 0, 1'b0);

    load(1, 4'd5);
    run_prog(2, 4, 6, 0, 1'b1);
    run_prog(2, 2, 2, 0, 1'b0);

    // reset during WAIT wipes outputs and program
    prog_len = 4'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'd0;
    chk("midrst_outs", {start, opcode, busy, cmd_idx, seq_done,
                        timeout_err, op_err}, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_idle("midrst_done");
    run_prog(1, 1, 1, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      done = 1'($urandom_range(1, 0));
      abort = 1'($urandom_range(1, 0));
      tick();
      done = 1'b0;
      abort = 1'b0;
      chk_idle("idle_noise");
      for (int w = 0; w < $urandom_range(4, 1); w++) begin
        if ($urandom_range(7, 0) == 0)
          load($urandom_range(7, 0), 4'($urandom_range(15, 0)));
        else
          load($urandom_range(7, 0), 4'($urandom_range(9, 3)));
      end
      run_prog($urandom_range(12, 0), 1, ($urandom_range(5, 0) == 0) ? 17 : 8,
               ($urandom_range(5, 0) == 0) ? $urandom_range(10, 1) : 0,
               1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
